// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, parameter
// defaults and the baud-rate constants used to size frame timing.
package uart_pkg;

    localparam int NUM_REQ_DEF        = 4;
    localparam int TIMEOUT_CYCLES_DEF = 8191;

    localparam int SYS_CLK      = 50_000_000;
    localparam int BAUD_RATE    = 115_200;
    localparam int CLKS_PER_BIT = SYS_CLK / BAUD_RATE;
    localparam int FRAME_BITS   = 10;
    localparam int FRAME_CLKS   = CLKS_PER_BIT * FRAME_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin picker: searches req starting one past the
// last-served index and returns a one-hot winner plus a valid flag.
module uart_rr_arb
    import uart_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] gnt,
    output logic               valid
);

    logic [IDX_W-1:0] idx;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((int'(last) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters: round-robin grant,
// byte capture, start pulse, then wait for completion or a bounded timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [8*NUM_REQ-1:0] i_data,
    output logic [NUM_REQ-1:0]   o_gnt,
    output logic [NUM_REQ-1:0]   o_done,
    output logic [7:0]           o_tx_d,
    output logic                 o_tx_en,
    input  logic                 i_tx_complete,
    output logic                 o_busy,
    output logic                 o_timeout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_d, done_d;
    logic [7:0]         tx_d_d;
    logic               tx_en_d, timeout_d;

    logic [NUM_REQ-1:0] win_gnt;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic [7:0]         win_byte;
    logic [NUM_REQ-1:0] owner_onehot;

    uart_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
        .req   (i_req),
        .last  (last_q),
        .gnt   (win_gnt),
        .valid (win_valid)
    );

    always_comb begin
        win_idx      = '0;
        win_byte     = '0;
        owner_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_gnt[i]) begin
                win_idx  = IDX_W'(i);
                win_byte = i_data[8*i +: 8];
            end
            owner_onehot[i] = (owner_q == IDX_W'(i));
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        tx_d_d    = o_tx_d;
        gnt_d     = '0;
        done_d    = '0;
        tx_en_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    gnt_d   = win_gnt;
                    tx_d_d  = win_byte;
                    owner_d = win_idx;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_en_d = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion is tested first so it wins over a coincident timeout.
                if (i_tx_complete) begin
                    done_d  = owner_onehot;
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    last_d    = owner_q;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            cnt_q     <= '0;
            o_gnt     <= '0;
            o_done    <= '0;
            o_tx_d    <= 8'h00;
            o_tx_en   <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            o_gnt     <= gnt_d;
            o_done    <= done_d;
            o_tx_d    <= tx_d_d;
            o_tx_en   <= tx_en_d;
            o_timeout <= timeout_d;
        end
    end

    assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table-driven single-frame vectors plus
// hand-written sequences for round-robin, timeout, reset and byte ordering.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N = 4;
    localparam int T = TIMEOUT_CYCLES_DEF;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   i_req;
    logic [8*N-1:0] i_data;
    logic [N-1:0]   o_gnt, o_done;
    logic [7:0]     o_tx_d;
    logic           o_tx_en, i_tx_complete, o_busy, o_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req         (i_req),
        .i_data        (i_data),
        .o_gnt         (o_gnt),
        .o_done        (o_done),
        .o_tx_d        (o_tx_d),
        .o_tx_en       (o_tx_en),
        .i_tx_complete (i_tx_complete),
        .o_busy        (o_busy),
        .o_timeout     (o_timeout)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [N-1:0]   req;
        logic [8*N-1:0] data;
        logic [N-1:0]   gnt;
        logic [7:0]     txd;
        int             delay;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        i_req         = '0;
        i_data        = '0;
        i_tx_complete = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (o_gnt != '0) break;
        end
    endtask

    task automatic complete_frame();
        i_tx_complete = 1'b1;
        tick();
        i_tx_complete = 1'b0;
    endtask

    task automatic run_frame(input int k, input vec_t v);
        int n;
        i_req  = v.req;
        i_data = v.data;
        wait_gnt(n);
        check($sformatf("v%0d grant latency", k), n, 1);
        check($sformatf("v%0d o_gnt", k), o_gnt, v.gnt);
        check($sformatf("v%0d o_tx_d", k), o_tx_d, v.txd);
        i_req = '0;
        tick();
        check($sformatf("v%0d o_tx_en", k), o_tx_en, 1);
        check($sformatf("v%0d o_gnt single", k), o_gnt, 0);
        repeat (v.delay - 1) tick();
        check($sformatf("v%0d o_tx_d held", k), o_tx_d, v.txd);
        check($sformatf("v%0d o_busy in wait", k), o_busy, 1);
        complete_frame();
        check($sformatf("v%0d o_done", k), o_done, v.gnt);
        check($sformatf("v%0d o_busy after", k), o_busy, 0);
        tick();
        check($sformatf("v%0d o_done single", k), o_done, 0);
    endtask

    initial begin
        int          n;
        logic        done_seen;
        logic [7:0]  got[3];
        logic [7:0]  exp_bytes[3];

        vecs[0] = '{4'b0100, 32'h0055_0000, 4'b0100, 8'h55, 100};
        vecs[1] = '{4'b1111, 32'hD4C3_B2A1, 4'b1000, 8'hD4, 5};
        vecs[2] = '{4'b1111, 32'hD4C3_B2A1, 4'b0001, 8'hA1, 5};
        vecs[3] = '{4'b0110, 32'hD4C3_B2A1, 4'b0010, 8'hB2, 5};
        vecs[4] = '{4'b1001, 32'hD4C3_B2A1, 4'b1000, 8'hD4, 5};
        vecs[5] = '{4'b0101, 32'hD4C3_B2A1, 4'b0001, 8'hA1, 5};
        vecs[6] = '{4'b0101, 32'hD4C3_B2A1, 4'b0100, 8'hC3, 5};
        vecs[7] = '{4'b0011, 32'hD4C3_B2A1, 4'b0001, 8'hA1, 5};

        // Reset state
        do_reset();
        check("reset o_gnt", o_gnt, 0);
        check("reset o_done", o_done, 0);
        check("reset o_tx_d", o_tx_d, 0);
        check("reset o_tx_en", o_tx_en, 0);
        check("reset o_busy", o_busy, 0);
        check("reset o_timeout", o_timeout, 0);

        // Table of independent frames; expectations follow the round-robin pointer.
        for (int k = 0; k < 8; k++) run_frame(k, vecs[k]);

        // All requesters held high from reset: grant order 0,1,2,3,0.
        do_reset();
        i_data = 32'h4433_2211;
        i_req  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(n);
            check($sformatf("rr%0d o_gnt", k), o_gnt, 32'(1 << (k % 4)));
            tick();
            repeat (3) tick();
            complete_frame();
        end
        i_req = '0;
        tick();

        // Complete during START is ignored; then no completion -> timeout after T clocks.
        do_reset();
        i_data = 32'h4433_2211;
        i_req  = 4'b0010;
        wait_gnt(n);
        check("to o_gnt", o_gnt, 4'b0010);
        i_req         = '0;
        i_tx_complete = 1'b1;
        tick();
        i_tx_complete = 1'b0;
        check("to o_tx_en", o_tx_en, 1);
        n         = 0;
        done_seen = 1'b0;
        for (int i = 0; i < T + 10; i++) begin
            tick();
            n++;
            if (o_done != '0) done_seen = 1'b1;
            if (o_timeout) break;
        end
        check("to latency", n, T);
        check("to no o_done", done_seen, 0);
        check("to o_busy", o_busy, 0);
        tick();
        check("to o_timeout single", o_timeout, 0);
        i_req = 4'b0001;
        wait_gnt(n);
        check("to next o_gnt", o_gnt, 4'b0001);
        i_req = '0;
        tick();
        complete_frame();
        check("to next o_done", o_done, 4'b0001);

        // Completion on the same edge as the timeout wins.
        i_req = 4'b1000;
        wait_gnt(n);
        check("tie o_gnt", o_gnt, 4'b1000);
        i_req = '0;
        tick();
        repeat (T - 1) tick();
        complete_frame();
        check("tie o_done", o_done, 4'b1000);
        check("tie o_timeout", o_timeout, 0);
        tick();

        // Asynchronous reset mid-WAIT.
        i_data = 32'h0055_0000;
        i_req  = 4'b0100;
        wait_gnt(n);
        i_req = '0;
        tick();
        repeat (20) tick();
        rst = 1'b1;
        #1;
        check("arst o_busy", o_busy, 0);
        check("arst o_tx_d", o_tx_d, 0);
        check("arst o_gnt", o_gnt, 0);
        check("arst o_tx_en", o_tx_en, 0);
        check("arst o_done", o_done, 0);
        check("arst o_timeout", o_timeout, 0);
        @(negedge clk);
        rst = 1'b0;
        complete_frame();
        check("arst no o_done", o_done, 0);
        i_req = 4'b1111;
        wait_gnt(n);
        check("arst first o_gnt", o_gnt, 4'b0001);
        i_req = '0;
        tick();
        complete_frame();

        // Byte ordering seen by the transmitter, requesters 0-2 pending together.
        do_reset();
        i_data       = {8'h00, 8'hFF, 8'hA3, 8'h55};
        exp_bytes[0] = 8'h55;
        exp_bytes[1] = 8'hA3;
        exp_bytes[2] = 8'hFF;
        i_req        = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            wait_gnt(n);
            i_req = i_req & ~o_gnt;
            tick();
            got[k] = o_tx_en ? o_tx_d : 8'hxx;
            repeat (10) tick();
            complete_frame();
        end
        for (int k = 0; k < 3; k++) check($sformatf("lb byte%0d", k), got[k], exp_bytes[k]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
